// File: rtl/round_hasher_pkg.sv
// Shared types and constants for the round_hasher block: FSM state encoding,
// default mixing constants and a generic rotate-left helper (widths up to 64).
package round_hasher_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ABSORB,
        MIX,
        DONE
    } state_e;

    localparam logic [31:0] DEFAULT_GOLDEN  = 32'h9E3779B9;
    localparam logic [31:0] DEFAULT_SEED    = 32'h0000_0000;
    localparam int          DEFAULT_ROT_AMT = 5;

    // Rotates the low 'width' bits of value left; bits above 'width' come back as zero.
    function automatic logic [63:0] rotl(input logic [63:0] value,
                                         input int unsigned width,
                                         input int unsigned distance);
        logic [63:0] mask;
        logic [63:0] v;
        int unsigned d;
        mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        v    = value & mask;
        d    = distance % width;
        if (d == 0) begin
            return v;
        end
        return ((v << d) | (v >> (width - d))) & mask;
    endfunction

endpackage

// File: rtl/round_hasher_if.sv
// Message-in / digest-out handshake bundle for round_hasher.
// The hasher uses the slave modport; the message source / hash consumer uses master.
interface round_hasher_if #(
    parameter int DATA_BYTES = 8,
    parameter int HASH_W     = 32
);
    localparam int LEN_W = $clog2(DATA_BYTES + 1);

    logic                    in_valid;
    logic                    in_ready;
    logic [8*DATA_BYTES-1:0] data;
    logic [LEN_W-1:0]        data_len;
    logic                    out_valid;
    logic                    out_ready;
    logic [HASH_W-1:0]       hash;

    modport master (
        output in_valid, data, data_len, out_ready,
        input  in_ready, out_valid, hash
    );

    modport slave (
        input  in_valid, data, data_len, out_ready,
        output in_ready, out_valid, hash
    );

endinterface

// File: rtl/round_hasher_rotator.sv
// Fixed-distance barrel rotator, left or right, for widths up to 64 bits.
module round_hasher_rotator
    import round_hasher_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit LEFT  = 1'b1,
    parameter int DIST  = 5
) (
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    localparam int unsigned LEFT_DIST = LEFT ? DIST : (WIDTH - DIST);

    // A right rotate by DIST is the same as a left rotate by WIDTH-DIST.
    assign dout_o = WIDTH'(rotl(64'(din_i), WIDTH, LEFT_DIST));

endmodule

// File: rtl/round_hasher.sv
// Multi-cycle hasher: absorbs one message byte per cycle, then runs ROUNDS mix steps.
// Optional macro ROUND_HASHER_CHAIN_EN seeds each message from the previous digest.
module round_hasher
    import round_hasher_pkg::*;
#(
    parameter int                DATA_BYTES = 8,
    parameter int                HASH_W     = 32,
    parameter int                ROUNDS     = 4,
    parameter int                ROT_AMT    = DEFAULT_ROT_AMT,
    parameter logic [HASH_W-1:0] SEED       = HASH_W'(DEFAULT_SEED),
    parameter logic [31:0]       GOLDEN     = DEFAULT_GOLDEN
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef ROUND_HASHER_CHAIN_EN
    input  logic                 chain_clr,
`endif
    round_hasher_if.slave        bus
);

    localparam int                LEN_W    = $clog2(DATA_BYTES + 1);
    localparam int                RND_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [HASH_W-1:0] GOLDEN_W = HASH_W'(GOLDEN);

    state_e                  state_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [HASH_W-1:0]       hash_q;
    logic [HASH_W-1:0]       s_q;
    logic [HASH_W-1:0]       s_d;
    logic [LEN_W-1:0]        idx_q;
    logic [LEN_W-1:0]        len_q;
    logic [RND_W-1:0]        rnd_q;
    logic [8*DATA_BYTES-1:0] data_q;

    logic [LEN_W-1:0]        lenClamped;
    logic [7:0]              curByte;
    logic [HASH_W-1:0]       rotIn;
    logic [HASH_W-1:0]       rotOut;
    logic [HASH_W-1:0]       startSeed;

`ifdef ROUND_HASHER_CHAIN_EN
    logic [HASH_W-1:0]       chain_q;
    assign startSeed = chain_clr ? SEED : chain_q;
`else
    assign startSeed = SEED;
`endif

    assign lenClamped = (bus.data_len > LEN_W'(DATA_BYTES)) ? LEN_W'(DATA_BYTES) : bus.data_len;
    assign curByte    = data_q[8*int'(idx_q) +: 8];

    // One rotator serves both phases; only the pre-rotate mixing and post-add differ.
    assign rotIn = (state_q == ABSORB) ? (s_q ^ HASH_W'(curByte))
                                       : (s_q ^ (s_q >> 16));

    round_hasher_rotator #(
        .WIDTH (HASH_W),
        .LEFT  (1'b1),
        .DIST  (ROT_AMT)
    ) u_rotator (
        .din_i  (rotIn),
        .dout_o (rotOut)
    );

    assign s_d = (state_q == ABSORB) ? (rotOut + GOLDEN_W) : (rotOut + HASH_W'(rnd_q));

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.hash      = hash_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            hash_q      <= '0;
            s_q         <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            rnd_q       <= '0;
            data_q      <= '0;
`ifdef ROUND_HASHER_CHAIN_EN
            chain_q     <= SEED;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_q     <= bus.data;
                        len_q      <= lenClamped;
                        s_q        <= startSeed;
                        idx_q      <= '0;
                        rnd_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= (lenClamped != '0) ? ABSORB : MIX;
                    end
                end
                ABSORB: begin
                    s_q   <= s_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == len_q - 1'b1) begin
                        state_q <= MIX;
                    end
                end
                MIX: begin
                    s_q   <= s_d;
                    rnd_q <= rnd_q + 1'b1;
                    if (rnd_q == RND_W'(ROUNDS - 1)) begin
                        hash_q      <= s_d ^ HASH_W'(len_q);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
`ifdef ROUND_HASHER_CHAIN_EN
                        chain_q     <= hash_q;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_hasher.sv
// Directed bench for round_hasher (ROUNDS=1, SEED=0); also exercises
// the chaining path when built with ROUND_HASHER_CHAIN_EN.
module tb_round_hasher;

    localparam int DATA_BYTES = 8;
    localparam int HASH_W     = 32;
    localparam int ROUNDS     = 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    round_hasher_if #(.DATA_BYTES(DATA_BYTES), .HASH_W(HASH_W)) bus ();

`ifdef ROUND_HASHER_CHAIN_EN
    logic chainClr;
`endif

    round_hasher #(
        .DATA_BYTES (DATA_BYTES),
        .HASH_W     (HASH_W),
        .ROUNDS     (ROUNDS),
        .SEED       (32'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef ROUND_HASHER_CHAIN_EN
        .chain_clr (chainClr),
`endif
        .bus       (bus)
    );

    typedef struct {
        logic [63:0] data;
        logic [3:0]  len;
        logic [31:0] expHash;
        int          expLat;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;

    // Straight-line reference: byte absorb then mix rounds, digest xored with clamped length.
    function automatic logic [31:0] modelHash(input logic [63:0] d, input int len, input logic [31:0] seed);
        logic [31:0] s;
        logic [31:0] x;
        int n;
        n = (len > DATA_BYTES) ? DATA_BYTES : len;
        s = seed;
        for (int i = 0; i < n; i++) begin
            x = s ^ {24'h0, d[8*i +: 8]};
            s = {x[26:0], x[31:27]} + 32'h9E3779B9;
        end
        for (int r = 0; r < ROUNDS; r++) begin
            x = s ^ {16'h0, s[31:16]};
            s = {x[26:0], x[31:27]} + 32'(r);
        end
        return s ^ 32'(n);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] d, input logic [3:0] len, input logic clr);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (bus.in_ready !== 1'b1) begin
            checkOutput("inReadyTimeout", 64'(bus.in_ready), 64'd1);
        end
        bus.in_valid = 1'b1;
        bus.data     = d;
        bus.data_len = len;
`ifdef ROUND_HASHER_CHAIN_EN
        chainClr     = clr;
`else
        if (clr) begin
            guard = 0;
        end
`endif
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.data     = {$urandom, $urandom};
        bus.data_len = 4'($urandom_range(0, 15));
`ifdef ROUND_HASHER_CHAIN_EN
        chainClr     = 1'b0;
`endif
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.out_valid !== 1'b1) begin
            checkOutput("outValidTimeout", 64'(bus.out_valid), 64'd1);
        end
    endtask

    task automatic popResult();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput("popOutValid", 64'(bus.out_valid), 64'd0);
        checkOutput("popInReady", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        logic [31:0] h1;
        logic [31:0] h2;
        logic [31:0] hExp;
        logic [63:0] msg;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.data      = '0;
        bus.data_len  = '0;
        bus.out_ready = 1'b0;
`ifdef ROUND_HASHER_CHAIN_EN
        chainClr      = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetInReady", 64'(bus.in_ready), 64'd1);
        checkOutput("resetOutValid", 64'(bus.out_valid), 64'd0);
        checkOutput("resetHash", 64'(bus.hash), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        vecs[0] = '{64'h0, 4'd0, 32'h0000_0000, 1};
        vecs[1] = '{64'h01, 4'd1, 32'hC6FC_FDD2, 2};
        vecs[2] = '{64'h0807060504030201, 4'd8, modelHash(64'h0807060504030201, 8, 32'h0), 9};
        vecs[3] = '{64'hDEADBEEFCAFEF00D, 4'd3, modelHash(64'hDEADBEEFCAFEF00D, 3, 32'h0), 4};
        vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 4'd8, modelHash(64'hFFFFFFFFFFFFFFFF, 8, 32'h0), 9};
        vecs[5] = '{64'h0123456789ABCDEF, 4'd8, modelHash(64'h0123456789ABCDEF, 8, 32'h0), 9};
        vecs[6] = '{64'h0123456789ABCDEF, 4'd15, modelHash(64'h0123456789ABCDEF, 8, 32'h0), 9};
        vecs[7] = '{64'h0123456789ABCDEF, 4'd5, modelHash(64'h0123456789ABCDEF, 5, 32'h0), 6};

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].data, vecs[v].len, 1'b1);
            waitResult(lat);
            checkOutput($sformatf("vec%0dHash", v), 64'(bus.hash), 64'(vecs[v].expHash));
            checkOutput($sformatf("vec%0dLatency", v), 64'(lat), 64'(vecs[v].expLat));
            popResult();
        end

        // Backpressure: digest must hold and a competing message must be ignored.
        msg  = 64'h00000000A5C3E1F0;
        hExp = modelHash(msg, 4, 32'h0);
        applyStimulus(msg, 4'd4, 1'b1);
        waitResult(lat);
        bus.in_valid = 1'b1;
        bus.data     = 64'h1111111111111111;
        bus.data_len = 4'd2;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("bpHash%0d", c), 64'(bus.hash), 64'(hExp));
            checkOutput($sformatf("bpInReady%0d", c), 64'(bus.in_ready), 64'd0);
            checkOutput($sformatf("bpOutValid%0d", c), 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        popResult();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bpNoStrayOutput", 64'(bus.out_valid), 64'd0);
        checkOutput("bpStillIdle", 64'(bus.in_ready), 64'd1);

        // Asynchronous reset while byte 3 is being absorbed.
        msg  = 64'h8877665544332211;
        hExp = modelHash(msg, 8, 32'h0);
        applyStimulus(msg, 4'd8, 1'b1);
        repeat (3) @(posedge clk);
        #3;
        checkOutput("preResetInReady", 64'(bus.in_ready), 64'd0);
        reset = 1'b1;
        #1;
        checkOutput("midResetInReady", 64'(bus.in_ready), 64'd1);
        checkOutput("midResetOutValid", 64'(bus.out_valid), 64'd0);
        checkOutput("midResetHash", 64'(bus.hash), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        applyStimulus(msg, 4'd8, 1'b0);
        waitResult(lat);
        checkOutput("postResetHash", 64'(bus.hash), 64'(hExp));
        checkOutput("postResetLatency", 64'(lat), 64'd9);
        popResult();

`ifdef ROUND_HASHER_CHAIN_EN
        msg  = 64'h00000000CAFEBABE;
        hExp = modelHash(msg, 4, 32'h0);
        applyStimulus(msg, 4'd4, 1'b1);
        waitResult(lat);
        h1 = bus.hash;
        checkOutput("chainFirst", 64'(h1), 64'(hExp));
        popResult();
        applyStimulus(msg, 4'd4, 1'b0);
        waitResult(lat);
        h2 = bus.hash;
        checkOutput("chainSecond", 64'(h2), 64'(modelHash(msg, 4, hExp)));
        checkOutput("chainDiffers", 64'(h2 != h1), 64'd1);
        popResult();
        applyStimulus(msg, 4'd4, 1'b1);
        waitResult(lat);
        checkOutput("chainCleared", 64'(bus.hash), 64'(hExp));
        popResult();
`else
        h1 = 32'h0;
        h2 = 32'h0;
        if (h1 != h2) begin
            $display("[TB] unexpected");
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
